fifo_wr_arbiter: RTL
====================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single write port of fifo_top between NUM_REQ requesters in the wr_clk domain.
//  Grants one requester per burst of up to BURST_LEN words, or fewer if it ends early, then rotates priority.
//  Sits directly upstream of fifo_top wr_en/wr_data/full. Never writes while full is high.
// PARAMETERS
//  DATA_SIZE  4  word width; matches fifo_top DATA_SIZE
//  NUM_REQ    4  number of requesters, >=2
//  BURST_LEN  4  max words per grant, >=1
// PORTS
//  wr_clk       in   1                   write-domain clock; sole clock
//  wr_rst       in   1                   synchronous, active-high reset
//  req_valid    in   NUM_REQ             per-requester word valid
//  req_last     in   NUM_REQ             per-requester last word of burst; qualified by valid
//  req_data     in   NUM_REQ*DATA_SIZE   packed; requester i at [i*DATA_SIZE +: DATA_SIZE]
//  req_ready    out  NUM_REQ             word accepted when valid&ready
//  fifo_wr_en   out  1                   to fifo_top wr_en
//  fifo_wr_data out  DATA_SIZE           to fifo_top wr_data
//  fifo_full    in   1                   from fifo_top full
//  gnt_id       out  $clog2(NUM_REQ)     current grantee; valid while gnt_busy
//  gnt_busy     out  1                   high in GRANT state
// BEHAVIOUR
//  Clock and reset: one clock (wr_clk). Reset is synchronous and active-high (wr_rst).
//  Reset values: state=IDLE, gnt_id=0, gnt_busy=0, cnt=0, last_id=NUM_REQ-1 (requester 0 wins first).
//  Reset mid-burst drops the grant with no partial-word write. Combinational outputs go low while wr_rst is high.
//  FSM:
//   IDLE:
//    - If any req_valid is set, pick the first set bit searching from last_id+1 upward with wrap.
//    - Register it in gnt_id and go to GRANT.
//    - Decision cycle: no transfer, all req_ready=0, fifo_wr_en=0.
//   GRANT (combinational handshake, zero latency):
//    - req_ready[gnt_id] = ~fifo_full; all other req_ready = 0.
//    - fifo_wr_en = req_valid[gnt_id] & ~fifo_full; fifo_wr_data = req_data slice gnt_id.
//    - Each transfer increments cnt. Width is $clog2(BURST_LEN+1).
//    - Return to IDLE, set last_id=gnt_id and clear cnt when any of these holds:
//      (a) the transfer carries req_last[gnt_id];
//      (b) the transfer is number BURST_LEN (cnt==BURST_LEN-1 at transfer);
//      (c) req_valid[gnt_id]=0 and fifo_full=0. This is an idle grantee.
//    - fifo_full=1 holds the grant indefinitely and does not count as release (c).
//  Boundary conditions:
//   - Every grant costs exactly 1 IDLE bubble cycle. Peak throughput is BURST_LEN/(BURST_LEN+1).
//   - Full asserted mid-burst: stall with req_ready low; resume on the same grantee, cnt preserved.
//   - req_last and count limit on the same transfer: single release.
//   - BURST_LEN=1: every transfer releases.
//   - Only one requester active: it is re-granted after each bubble.
//   - Non-granted requesters must hold valid/data stable. The arbiter never drops or duplicates a word.
//   - A valid that appears during GRANT is considered only at the next IDLE.
//   - fifo_wr_en is never high when fifo_full is high, in any state.
// STRUCTURE
//  Shared package fifo_arb_pkg:
//   - state encoding localparams ST_IDLE=1'b0, ST_GRANT=1'b1
//   - function clog2_min1(n), returning max(1,$clog2(n)), for gnt_id/last_id widths
//  Sub-module rr_pick #(N): purely combinational.
//   - inputs req[N], last_id; outputs any, pick_id
//   - implemented as a double-width masked priority encode
//  Top holds the FSM, cnt, last_id, gnt_id and output muxing.
// TESTING
//  1. Single requester: req_valid=4'b0001, burst of 6 words, BURST_LEN=4.
//     -> 4 writes, 1 bubble, 2 writes; gnt_id=0 throughout; FIFO readback matches order.
//  2. All 4 requesters continuously valid, no req_last.
//     -> grants in order 0,1,2,3,0; each grant is exactly 4 writes; 1 bubble between grants.
//  3. Requester 2 holding grant, fifo_full forced high for 5 cycles after word 2.
//     -> req_ready[2]=0 and fifo_wr_en=0 for 5 cycles; then words 3-4 written; no loss or duplicate.
//  4. req_last on requester 1's second word with requester 3 also pending.
//     -> release after 2 words; next grant is 3; requester 2 is skipped because it is not valid.
//  5. wr_rst pulsed during requester 1's burst.
//     -> next cycle: gnt_busy=0, all req_ready=0; first grant after reset goes to requester 0 if it is valid.
//  6. Grantee drops valid with full=0 after 1 word.
//     -> release in that cycle; next requester is granted after 1 bubble.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared state encoding and width helper for the write-port arbiter
// Purpose: state encoding used by the FSM and the id-width helper shared by
//          the interface, the round-robin picker and the top.
// Ports:   none (package).
package fifo_arb_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  typedef enum logic {
    IDLE  = ST_IDLE,
    GRANT = ST_GRANT
  } arb_state_e;

  // Width of an id field; never zero so a 1-bit id still exists for tiny configs.
  function automatic int clog2_min1(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - requester and fifo_top write-port bundle for the arbiter
// Purpose: groups requester handshakes, the fifo_top write port and grant status.
// Ports (signals):
//   req_valid/req_last/req_data  requester side, driven by requesters
//   req_ready                    per-requester accept, driven by the arbiter
//   fifo_wr_en/fifo_wr_data      to fifo_top write port
//   fifo_full                    from fifo_top
//   gnt_id/gnt_busy              grant status
// Modports: master = arbiter, slave = requesters plus fifo_top.
interface fifo_wr_arbiter_if import fifo_arb_pkg::*; #(
  parameter int DATA_SIZE = 4,
  parameter int NUM_REQ   = 4
) ();

  localparam int ID_W = clog2_min1(NUM_REQ);

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_last;
  logic [NUM_REQ*DATA_SIZE-1:0] req_data;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         fifo_wr_en;
  logic [DATA_SIZE-1:0]         fifo_wr_data;
  logic                         fifo_full;
  logic [ID_W-1:0]              gnt_id;
  logic                         gnt_busy;

  modport master (
    input  req_valid, req_last, req_data, fifo_full,
    output req_ready, fifo_wr_en, fifo_wr_data, gnt_id, gnt_busy
  );

  modport slave (
    output req_valid, req_last, req_data, fifo_full,
    input  req_ready, fifo_wr_en, fifo_wr_data, gnt_id, gnt_busy
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - combinational round-robin picker
// Purpose: returns the first set request strictly after last_id, wrapping.
// Ports:
//   req      in  N  request vector
//   last_id  in  W  previous winner
//   any      out 1  at least one request set
//   pick_id  out W  chosen requester (valid when any)
module rr_pick import fifo_arb_pkg::*; #(
  parameter int N = 4,
  localparam int W = clog2_min1(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last_id,
  output logic         any,
  output logic [W-1:0] pick_id
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] masked;

  // The upper copy of req supplies the wrapped-around candidates, so masking
  // off everything at or below last_id leaves a plain lowest-bit search.
  always_comb begin
    dbl     = {req, req};
    masked  = '0;
    any     = |req;
    pick_id = '0;
    for (int i = 0; i < 2*N; i++) begin
      masked[i] = dbl[i] && (i > int'(last_id));
    end
    for (int i = 2*N-1; i >= 0; i--) begin
      if (masked[i]) pick_id = W'(i % N);
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin arbiter for the single fifo_top write port
// Purpose: grants one requester per burst of up to BURST_LEN words, one idle
//          decision cycle per grant, never writes while fifo_full is high.
// Ports:
//   wr_clk  in  1  sole clock
//   wr_rst  in  1  synchronous active-high reset
//   bus     fifo_wr_arbiter_if.master  requester handshakes, fifo write port, grant status
module fifo_wr_arbiter import fifo_arb_pkg::*; #(
  parameter int DATA_SIZE = 4,
  parameter int NUM_REQ   = 4,
  parameter int BURST_LEN = 4
) (
  input  logic              wr_clk,
  input  logic              wr_rst,
  fifo_wr_arbiter_if.master bus
);

  localparam int ID_W  = clog2_min1(NUM_REQ);
  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);
  localparam logic [ID_W-1:0]  ID_MAX   = ID_W'(NUM_REQ - 1);

  arb_state_e       state_q, state_d;
  logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
  logic [ID_W-1:0]  last_id_q, last_id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             any_req;
  logic [ID_W-1:0]  pick_id;
  logic             in_grant;
  logic             gnt_valid;
  logic             gnt_last;
  logic             xfer;
  logic             rel;
  logic [NUM_REQ-1:0] ready;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req     (bus.req_valid),
    .last_id (last_id_q),
    .any     (any_req),
    .pick_id (pick_id)
  );

  // Reset gates every combinational output so nothing leaks mid-burst.
  assign in_grant  = (state_q == GRANT) && !wr_rst;
  assign gnt_valid = bus.req_valid[gnt_id_q];
  assign gnt_last  = bus.req_last[gnt_id_q];
  assign xfer      = in_grant && gnt_valid && !bus.fifo_full;

  // A full FIFO stalls the grant rather than releasing it as an idle grantee.
  assign rel = in_grant &&
               ((xfer && (gnt_last || (cnt_q == CNT_LAST))) ||
                (!gnt_valid && !bus.fifo_full));

  always_comb begin
    ready = '0;
    if (in_grant && !bus.fifo_full) ready[gnt_id_q] = 1'b1;
  end

  assign bus.req_ready    = ready;
  assign bus.fifo_wr_en   = xfer;
  assign bus.fifo_wr_data = bus.req_data[gnt_id_q*DATA_SIZE +: DATA_SIZE];
  assign bus.gnt_id       = gnt_id_q;
  assign bus.gnt_busy     = in_grant;

  always_comb begin
    state_d   = state_q;
    gnt_id_d  = gnt_id_q;
    last_id_d = last_id_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d  = GRANT;
          gnt_id_d = pick_id;
        end
      end
      GRANT: begin
        if (rel) begin
          state_d   = IDLE;
          last_id_d = gnt_id_q;
          cnt_d     = '0;
        end else if (xfer) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      state_q   <= IDLE;
      gnt_id_q  <= '0;
      last_id_q <= ID_MAX;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_id_q  <= gnt_id_d;
      last_id_q <= last_id_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule
